mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the pipelined RISC-V core. It sits directly downstream of the EX/MEM register and consumes its outputs.
- Performs data-memory load/store against an internal word RAM with a configurable access latency, and raises a stall to the hazard unit while an access is in flight.
- Resolves the branch (pcsrc/target) and holds the MEM/WB pipeline register that feeds writeback.

Parameters:
- ADDR_BITS, 8, word-address width; RAM depth = 2**ADDR_BITS words of 32 bits.
- MEM_LATENCY, 2, wait cycles per load/store (legal 0..15); access occupies MEM_LATENCY+1 cycles.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- alures_ex  in  32  ALU result; byte address for loads/stores, writeback value otherwise.
- b_ex  in  32  store data.
- rd_ex  in  5  destination register.
- sumB_ex  in  32  branch target.
- zero_ex, branch_ex  in  1 each  branch qualifiers.
- memread_ex, memwrite_ex, memtoreg_ex, regwrite_ex  in  1 each  control.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM (combinational).
- pcsrc  out  1  branch_ex & zero_ex; forced 0 while rst_n=0.
- target  out  32  equals sumB_ex.
- memdata_wb  out  32  registered load data.
- alures_wb  out  32  registered alures_ex.
- rd_wb  out  5  registered destination register.
- memtoreg_wb, regwrite_wb  out  1 each  registered control.

Behaviour:
- Reset (rst_n=0 at posedge):
  - FSM goes to IDLE; counter cleared.
  - All *_wb outputs become 0; stall=0.
  - RAM contents are not reset.
- Address: word index = alures_ex[ADDR_BITS+1:2]. Bits [1:0] are ignored; upper bits wrap modulo depth.
- FSM states IDLE and WAIT; cnt is 4 bits.
  - IDLE, no access (memread_ex=memwrite_ex=0): stall=0. MEM/WB captures the EX/MEM values; memdata_wb<=0.
  - IDLE, access, MEM_LATENCY=0: completes the same cycle (see Completion); stall=0.
  - IDLE, access, MEM_LATENCY>0: stall=1; cnt<=MEM_LATENCY-1; go to WAIT; MEM/WB loads a bubble (regwrite_wb<=0, memtoreg_wb<=0, rd_wb<=0).
  - WAIT, cnt!=0: stall=1; cnt<=cnt-1; bubble into MEM/WB.
  - WAIT, cnt==0: stall=0; Completion; go to IDLE.
- Completion:
  - Write: RAM[idx]<=b_ex.
  - Read: memdata_wb<=RAM[idx], giving the pre-write value; the RAM read is synchronous, folded into the MEM/WB capture.
  - MEM/WB captures alures_ex, rd_ex, memtoreg_ex and regwrite_ex.
- EX/MEM inputs are held stable by the upstream freeze while stall=1. The block samples them only on the start and completion cycles.
- memread_ex & memwrite_ex both 1: illegal. The write is performed and memdata_wb=0.
- Back-to-back accesses: the cycle after completion is IDLE; a new access starts immediately, with no dead cycle.
- Reset mid-access: the FSM aborts to IDLE, no write is performed, and stall=0 on the following cycle.
- Load-to-writeback latency, measured from the start cycle: MEM_LATENCY+1 clocks.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_wb (1 bit, reset 0).
  - An access with alures_ex[1:0]!=0 skips the FSM: stall=0, no RAM write, regwrite_wb<=0, memdata_wb<=0, misalign_wb<=1 for one cycle.
  - A non-access instruction sets misalign_wb<=0.
- Undefined: no port; low address bits are silently ignored.

Test Plan:
- Reset: hold rst_n=0 with branch_ex=zero_ex=1, memwrite_ex=1 -> pcsrc=0, stall=0, all *_wb=0; no RAM write occurs.
- Store/load, MEM_LATENCY=2: sw 0xDEADBEEF to 0x10 -> stall high 2 cycles, then lw 0x10 with rd=5 -> stall 2 cycles, then memdata_wb=0xDEADBEEF, rd_wb=5, regwrite_wb=1, memtoreg_wb=1; bubbles (regwrite_wb=0) during stall cycles.
- MEM_LATENCY=0: alternating sw/lw every cycle to 0x4 -> stall never asserts; each lw returns the preceding sw data one clock later.
- ALU-only: add with alures_ex=0x1234, rd=3, regwrite=1 -> next clock alures_wb=0x1234, rd_wb=3, stall=0; branch_ex=1, zero_ex=1, sumB_ex=0x80 -> pcsrc=1, target=0x80 same cycle.
- Reset mid-access: sw 0x55 to 0x20 with rst_n dropped in the first WAIT cycle -> stall=0 after reset; a subsequent lw 0x20 does not return 0x55 (preload 0xAA first, expect 0xAA).
- Misalign (macro defined): lw at 0x13 -> stall=0, misalign_wb=1 next clock, regwrite_wb=0; macro undefined -> reads word 0x10.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: data-memory access with a fixed wait latency, branch resolution and the MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alures_ex,
  input  logic [31:0] b_ex,
  input  logic [4:0]  rd_ex,
  input  logic [31:0] sumB_ex,
  input  logic        zero_ex,
  input  logic        branch_ex,
  input  logic        memread_ex,
  input  logic        memwrite_ex,
  input  logic        memtoreg_ex,
  input  logic        regwrite_ex,
  output logic        stall,
  output logic        pcsrc,
  output logic [31:0] target,
  output logic [31:0] memdata_wb,
  output logic [31:0] alures_wb,
  output logic [4:0]  rd_wb,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  output logic        misalign_wb,
`endif
  output logic        memtoreg_wb,
  output logic        regwrite_wb
);

  localparam int         DEPTH    = 2 ** ADDR_BITS;
  localparam bit         ZERO_LAT = (MEM_LATENCY == 0);
  localparam logic [3:0] LAT_M1   = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                 state_reg, state_next;
  logic [3:0]             cnt_reg, cnt_next;
  logic                   stall_raw;
  logic                   complete;
  logic                   bubble;
  logic                   access;
  logic                   misaligned;
  logic [ADDR_BITS-1:0]   idx;
  logic [31:0]            ram [DEPTH];

  assign access = memread_ex | memwrite_ex;
  assign idx    = alures_ex[ADDR_BITS+1:2];

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  // A misaligned access is only recognised where it would otherwise start.
  assign misaligned = access && (alures_ex[1:0] != 2'b00) && (state_reg == IDLE);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_raw  = 1'b0;
    complete   = 1'b0;
    bubble     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (access && !misaligned) begin
          if (ZERO_LAT) begin
            complete = 1'b1;
          end else begin
            stall_raw  = 1'b1;
            bubble     = 1'b1;
            cnt_next   = LAT_M1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg != 4'd0) begin
          stall_raw = 1'b1;
          bubble    = 1'b1;
          cnt_next  = cnt_reg - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset must release the upstream freeze immediately, even mid-access.
  assign stall  = stall_raw & rst_n;
  assign pcsrc  = rst_n & branch_ex & zero_ex;
  assign target = sumB_ex;

  // RAM contents survive reset; writes land only on the completion cycle.
  always_ff @(posedge clk) begin
    if (rst_n && complete && memwrite_ex) begin
      ram[idx] <= b_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memdata_wb  <= 32'd0;
      alures_wb   <= 32'd0;
      rd_wb       <= 5'd0;
      memtoreg_wb <= 1'b0;
      regwrite_wb <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign_wb <= 1'b0;
`endif
    end else if (misaligned) begin
      memdata_wb  <= 32'd0;
      alures_wb   <= alures_ex;
      rd_wb       <= rd_ex;
      memtoreg_wb <= memtoreg_ex;
      regwrite_wb <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign_wb <= 1'b1;
`endif
    end else if (bubble) begin
      rd_wb       <= 5'd0;
      memtoreg_wb <= 1'b0;
      regwrite_wb <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign_wb <= 1'b0;
`endif
    end else begin
      // Read-before-write: a load sees the word as it was before this cycle.
      memdata_wb  <= (complete && memread_ex && !memwrite_ex) ? ram[idx] : 32'd0;
      alures_wb   <= alures_ex;
      rd_wb       <= rd_ex;
      memtoreg_wb <= memtoreg_ex;
      regwrite_wb <= regwrite_ex;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign_wb <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: one instance at MEM_LATENCY=2 and one at MEM_LATENCY=0.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alures_ex, b_ex, sumB_ex;
  logic [4:0]  rd_ex;
  logic        zero_ex, branch_ex, memread_ex, memwrite_ex, memtoreg_ex, regwrite_ex;

  logic        stall_2, pcsrc_2, memtoreg_2, regwrite_2;
  logic [31:0] target_2, memdata_2, alures_2;
  logic [4:0]  rd_2;
  logic        stall_0, pcsrc_0, memtoreg_0, regwrite_0;
  logic [31:0] target_0, memdata_0, alures_0;
  logic [4:0]  rd_0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic        misalign_2, misalign_0;
`endif

  always #5 clk = ~clk;

  mem_stage #(.ADDR_BITS(8), .MEM_LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .alures_ex(alures_ex), .b_ex(b_ex), .rd_ex(rd_ex),
    .sumB_ex(sumB_ex), .zero_ex(zero_ex), .branch_ex(branch_ex),
    .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
    .memtoreg_ex(memtoreg_ex), .regwrite_ex(regwrite_ex),
    .stall(stall_2), .pcsrc(pcsrc_2), .target(target_2), .memdata_wb(memdata_2),
    .alures_wb(alures_2), .rd_wb(rd_2),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    .misalign_wb(misalign_2),
`endif
    .memtoreg_wb(memtoreg_2), .regwrite_wb(regwrite_2)
  );

  mem_stage #(.ADDR_BITS(8), .MEM_LATENCY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .alures_ex(alures_ex), .b_ex(b_ex), .rd_ex(rd_ex),
    .sumB_ex(sumB_ex), .zero_ex(zero_ex), .branch_ex(branch_ex),
    .memread_ex(memread_ex), .memwrite_ex(memwrite_ex),
    .memtoreg_ex(memtoreg_ex), .regwrite_ex(regwrite_ex),
    .stall(stall_0), .pcsrc(pcsrc_0), .target(target_0), .memdata_wb(memdata_0),
    .alures_wb(alures_0), .rd_wb(rd_0),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    .misalign_wb(misalign_0),
`endif
    .memtoreg_wb(memtoreg_0), .regwrite_wb(regwrite_0)
  );

  localparam int M_STALL = 1, M_PC = 2, M_TGT = 4, M_MD = 8, M_AR = 16,
                 M_RD = 32, M_MT = 64, M_RW = 128, M_MIS = 256;

  typedef struct {
    int          cyc;
    bit          dut;
    int          mask;
    string       name;
    logic        stall;
    logic        pcsrc;
    logic [31:0] target;
    logic [31:0] memdata;
    logic [31:0] alures;
    logic [4:0]  rd;
    logic        memtoreg;
    logic        regwrite;
    logic        misalign;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  function automatic void cmp(string nm, string field, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, field, act, req);
    end
  endfunction

  function automatic void check(exp_t e);
    logic s, p, mt, rw, mis;
    logic [31:0] t, md, ar;
    logic [4:0] r;
    mis = 1'b0;
    if (e.dut) begin
      s = stall_0; p = pcsrc_0; t = target_0; md = memdata_0; ar = alures_0;
      r = rd_0; mt = memtoreg_0; rw = regwrite_0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      mis = misalign_0;
`endif
    end else begin
      s = stall_2; p = pcsrc_2; t = target_2; md = memdata_2; ar = alures_2;
      r = rd_2; mt = memtoreg_2; rw = regwrite_2;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      mis = misalign_2;
`endif
    end
    if ((e.mask & M_STALL) != 0) cmp(e.name, "stall", 32'(s), 32'(e.stall));
    if ((e.mask & M_PC) != 0)    cmp(e.name, "pcsrc", 32'(p), 32'(e.pcsrc));
    if ((e.mask & M_TGT) != 0)   cmp(e.name, "target", t, e.target);
    if ((e.mask & M_MD) != 0)    cmp(e.name, "memdata_wb", md, e.memdata);
    if ((e.mask & M_AR) != 0)    cmp(e.name, "alures_wb", ar, e.alures);
    if ((e.mask & M_RD) != 0)    cmp(e.name, "rd_wb", 32'(r), 32'(e.rd));
    if ((e.mask & M_MT) != 0)    cmp(e.name, "memtoreg_wb", 32'(mt), 32'(e.memtoreg));
    if ((e.mask & M_RW) != 0)    cmp(e.name, "regwrite_wb", 32'(rw), 32'(e.regwrite));
    if ((e.mask & M_MIS) != 0)   cmp(e.name, "misalign_wb", 32'(mis), 32'(e.misalign));
  endfunction

  // Monitor: pops every expectation due this cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i]);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d expired at cycle %0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end
    end
  end

  function automatic void push(int c, bit d, int m, string nm, logic s, logic p, logic [31:0] t,
                               logic [31:0] md, logic [31:0] ar, logic [4:0] r, logic mt,
                               logic rw, logic mis);
    exp_t e;
    e.cyc = c; e.dut = d; e.mask = m; e.name = nm;
    e.stall = s; e.pcsrc = p; e.target = t; e.memdata = md; e.alures = ar;
    e.rd = r; e.memtoreg = mt; e.regwrite = rw; e.misalign = mis;
    sb.push_back(e);
  endfunction

  function automatic void chk_stall(int c, bit d, string nm, logic s);
    push(c, d, M_STALL, nm, s, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic void chk_bubble(int c, bit d, string nm);
    push(c, d, M_RD | M_MT | M_RW, nm, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic void chk_wb(int c, bit d, string nm, logic [31:0] md, logic [31:0] ar,
                                 logic [4:0] r, logic mt, logic rw, bit chk_md);
    push(c, d, (chk_md ? M_MD : 0) | M_AR | M_RD | M_MT | M_RW, nm,
         1'b0, 1'b0, 32'd0, md, ar, r, mt, rw, 1'b0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (cyc > 5000) begin
      $display("FAIL watchdog: got cycle %0d expected below 5000", cyc);
      $fatal(1, "watchdog expired");
    end
  endtask

  task automatic idle();
    memread_ex = 1'b0; memwrite_ex = 1'b0; memtoreg_ex = 1'b0; regwrite_ex = 1'b0;
    branch_ex = 1'b0; zero_ex = 1'b0; rd_ex = 5'd0; b_ex = 32'd0; alures_ex = 32'd0;
  endtask

  task automatic set_op(bit r, bit w, logic [31:0] addr, logic [31:0] data, logic [4:0] rd,
                        bit mt, bit rw);
    memread_ex = r; memwrite_ex = w; alures_ex = addr; b_ex = data;
    rd_ex = rd; memtoreg_ex = mt; regwrite_ex = rw; branch_ex = 1'b0; zero_ex = 1'b0;
  endtask

  // Access on the latency-2 instance: stall for 2 cycles, result visible 3 clocks after start.
  task automatic acc2(string nm, bit r, bit w, logic [31:0] addr, logic [31:0] data,
                      logic [4:0] rd, bit mt, bit rw, logic [31:0] md, bit chk_md);
    int c;
    set_op(r, w, addr, data, rd, mt, rw);
    c = cyc;
    chk_stall(c, 1'b0, nm, 1'b1);
    chk_stall(c + 1, 1'b0, nm, 1'b1);
    chk_bubble(c + 1, 1'b0, nm);
    chk_stall(c + 2, 1'b0, nm, 1'b0);
    chk_bubble(c + 2, 1'b0, nm);
    chk_wb(c + 3, 1'b0, nm, md, addr, rd, mt, rw, chk_md);
    repeat (3) step();
  endtask

  // Access on the zero-latency instance: never stalls, result one clock later.
  task automatic acc0(string nm, bit r, bit w, logic [31:0] addr, logic [31:0] data,
                      logic [4:0] rd, bit mt, bit rw, logic [31:0] md);
    int c;
    set_op(r, w, addr, data, rd, mt, rw);
    c = cyc;
    chk_stall(c, 1'b1, nm, 1'b0);
    chk_wb(c + 1, 1'b1, nm, md, addr, rd, mt, rw, 1'b1);
    step();
  endtask

  initial begin
    int c;
    // Reset held with a pending store and a taken branch.
    rst_n = 1'b0;
    idle();
    branch_ex = 1'b1; zero_ex = 1'b1; memwrite_ex = 1'b1;
    alures_ex = 32'h40; b_ex = 32'h99; rd_ex = 5'd4; regwrite_ex = 1'b1; sumB_ex = 32'h100;
    for (int k = 0; k < 2; k++) begin
      step();
      for (int d = 0; d < 2; d++)
        push(cyc, d[0], M_STALL | M_PC | M_TGT | M_MD | M_AR | M_RD | M_MT | M_RW, "reset",
             1'b0, 1'b0, 32'h100, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    step();
    rst_n = 1'b1;
    idle();

    // ALU-only instruction with a taken branch.
    alures_ex = 32'h1234; rd_ex = 5'd3; regwrite_ex = 1'b1;
    branch_ex = 1'b1; zero_ex = 1'b1; sumB_ex = 32'h80;
    c = cyc;
    for (int d = 0; d < 2; d++) begin
      push(c, d[0], M_STALL | M_PC | M_TGT, "alu_branch", 1'b0, 1'b1, 32'h80,
           32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_wb(c + 1, d[0], "alu_wb", 32'd0, 32'h1234, 5'd3, 1'b0, 1'b1, 1'b1);
      push(c + 1, d[0], M_STALL | M_PC | M_TGT, "no_branch", 1'b0, 1'b0, 32'h80,
           32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    step();
    idle();
    step();

    // Latency 2: store, back-to-back load, then a load with low address bits set.
    acc2("sw_10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    acc2("lw_10", 1'b1, 1'b0, 32'h10, 32'd0, 5'd5, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    set_op(1'b1, 1'b0, 32'h13, 32'd0, 5'd6, 1'b1, 1'b1);
    c = cyc;
    chk_stall(c, 1'b0, "lw_13_trap", 1'b0);
    push(c + 1, 1'b0, M_MD | M_RW | M_MIS, "lw_13_trap", 1'b0, 1'b0, 32'd0,
         32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step();
    idle();
    push(c + 2, 1'b0, M_MIS, "trap_clear", 1'b0, 1'b0, 32'd0,
         32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step();
`else
    acc2("lw_13", 1'b1, 1'b0, 32'h13, 32'd0, 5'd6, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
`endif
    idle();
    step();

    // Latency 0: alternating store/load to 0x4, plus the illegal read+write case.
    acc0("sw0_a", 1'b0, 1'b1, 32'h4, 32'h11111111, 5'd0, 1'b0, 1'b0, 32'd0);
    acc0("lw0_a", 1'b1, 1'b0, 32'h4, 32'd0, 5'd7, 1'b1, 1'b1, 32'h11111111);
    acc0("sw0_b", 1'b0, 1'b1, 32'h4, 32'h22222222, 5'd0, 1'b0, 1'b0, 32'd0);
    acc0("lw0_b", 1'b1, 1'b0, 32'h4, 32'd0, 5'd7, 1'b1, 1'b1, 32'h22222222);
    acc0("rw0_illegal", 1'b1, 1'b1, 32'h4, 32'h44444444, 5'd7, 1'b1, 1'b1, 32'd0);
    acc0("lw0_c", 1'b1, 1'b0, 32'h4, 32'd0, 5'd7, 1'b1, 1'b1, 32'h44444444);

    // Clean reset, then abort a store in its first wait cycle.
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
    step();
    acc2("sw_20_pre", 1'b0, 1'b1, 32'h20, 32'hAA, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    set_op(1'b0, 1'b1, 32'h20, 32'h55, 5'd0, 1'b0, 1'b0);
    c = cyc;
    chk_stall(c, 1'b0, "rst_mid_start", 1'b1);
    step();
    rst_n = 1'b0;
    chk_stall(c + 1, 1'b0, "rst_mid_held", 1'b0);
    step();
    rst_n = 1'b1;
    idle();
    chk_stall(c + 2, 1'b0, "rst_mid_after", 1'b0);
    chk_bubble(c + 2, 1'b0, "rst_mid_after");
    step();
    acc2("lw_20", 1'b1, 1'b0, 32'h20, 32'd0, 5'd9, 1'b1, 1'b1, 32'hAA, 1'b1);
    idle();

    for (int k = 0; k < 10 && sb.size() > 0; k++) step();
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
